// File: rtl/riscv_run_pkg.sv
// Shared types and constants for the run controller: FSM state encoding
// and the exit code that counts as a successful halt.
package riscv_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_PASS    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_TIMEOUT = 3'd5
  } run_state_e;

  localparam logic [31:0] EXIT_PASS = 32'h0;

  // True in any terminal state, where results are held and a new run may start.
  function automatic logic is_done_state(input run_state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/riscv_halt_capture.sv
// Per-core sticky halt flag and exit-code register. The first halt seen
// while enabled is kept; later strobes from the same core are ignored.
module riscv_halt_capture
  import riscv_run_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic        i_halt,
  input  logic [31:0] i_code,
  output logic        o_halted,
  output logic        o_fail
);

  logic        r_halted;
  logic [31:0] r_code;

  // Capture the first halt and its code; clear on reset or start of a new run.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_halted <= 1'b0;
      r_code   <= '0;
    end else if (i_en && i_halt && !r_halted) begin
      r_halted <= 1'b1;
      r_code   <= i_code;
    end
  end

  assign o_halted = r_halted;
  assign o_fail   = r_halted && (r_code != EXIT_PASS);

endmodule

// File: rtl/riscv_run_controller.sv
// Run controller: holds cores in reset, releases them for a bounded run,
// collects per-core halts and reports pass, fail or timeout.
module riscv_run_controller
  import riscv_run_pkg::*;
#(
  parameter int NUM_CORES    = 1,
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 200,
  parameter int CNT_W        = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [NUM_CORES-1:0]    i_halt,
  input  logic [32*NUM_CORES-1:0] i_halt_code,
  output logic [NUM_CORES-1:0]    o_core_rstn,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic                    o_timeout,
  output logic [NUM_CORES-1:0]    o_fail_mask,
  output logic [NUM_CORES-1:0]    o_halted_mask,
  output logic [CNT_W-1:0]        o_cycles
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  run_state_e           r_state;
  run_state_e           w_next;
  logic [RC_W-1:0]      r_rst_cnt;
  logic [CNT_W-1:0]     r_cycles;

  logic                 w_clear;
  logic                 w_rst_last;
  logic                 w_last_cycle;
  logic                 w_complete;
  logic                 w_any_fail;
  logic [NUM_CORES-1:0] w_halted;
  logic [NUM_CORES-1:0] w_fail;
  logic [NUM_CORES-1:0] w_new_fail;

  // A start is only accepted when no run is active.
  assign w_clear      = i_start && ((r_state == ST_IDLE) || is_done_state(r_state));
  assign w_rst_last   = (r_rst_cnt == RC_W'(RESET_CYCLES - 1));
  assign w_last_cycle = (r_cycles == CNT_W'(MAX_CYCLES - 1));

  genvar k;
  generate
    for (k = 0; k < NUM_CORES; k++) begin : g_core
      riscv_halt_capture u_cap (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_clear),
        .i_en     (r_state == ST_RUN),
        .i_halt   (i_halt[k]),
        .i_code   (i_halt_code[32*k +: 32]),
        .o_halted (w_halted[k]),
        .o_fail   (w_fail[k])
      );
      // A halt arriving this cycle on a not-yet-halted core also decides the verdict.
      assign w_new_fail[k] = i_halt[k] && !w_halted[k] &&
                             (i_halt_code[32*k +: 32] != EXIT_PASS);
    end
  endgenerate

  assign w_complete = &(w_halted | i_halt);
  assign w_any_fail = |(w_fail | w_new_fail);

  // Next-state logic: abort beats completion, completion beats timeout.
  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_RESET;
      ST_RESET: begin
        if (i_abort)         w_next = ST_IDLE;
        else if (w_rst_last) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (i_abort)           w_next = ST_IDLE;
        else if (w_complete)   w_next = w_any_fail ? ST_FAIL : ST_PASS;
        else if (w_last_cycle) w_next = ST_TIMEOUT;
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: if (i_start) w_next = ST_RESET;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Reset-hold counter: runs only while in RESET, zero otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                   r_rst_cnt <= '0;
    else if ((r_state == ST_RESET) && !w_rst_last) r_rst_cnt <= r_rst_cnt + 1'b1;
    else                                         r_rst_cnt <= '0;
  end

  // RUN-cycle counter: cleared on start, frozen on abort and in every other state.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_clear)                     r_cycles <= '0;
    else if ((r_state == ST_RUN) && !i_abort) r_cycles <= r_cycles + 1'b1;
  end

  assign o_core_rstn   = {NUM_CORES{r_state == ST_RUN}};
  assign o_busy        = (r_state == ST_RESET) || (r_state == ST_RUN);
  assign o_done        = is_done_state(r_state);
  assign o_pass        = (r_state == ST_PASS);
  assign o_timeout     = (r_state == ST_TIMEOUT);
  assign o_fail_mask   = w_fail;
  assign o_halted_mask = w_halted;
  assign o_cycles      = r_cycles;

endmodule

// File: tb/tb_riscv_run_controller.sv
// Bench for riscv_run_controller with two cores: directed runs with
// hand-computed verdicts, checked by a monitor that pops a result queue
// each time o_done rises.
module tb_riscv_run_controller;

  localparam int NC = 2;
  localparam int RC = 4;
  localparam int MC = 200;

  typedef struct {
    logic        pass;
    logic        timeout;
    logic [1:0]  fail;
    logic [1:0]  halted;
    logic [31:0] cycles;
  } exp_t;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_abort;
  logic [NC-1:0] i_halt;
  logic [63:0]   i_halt_code;
  logic [NC-1:0] o_core_rstn;
  logic          o_busy, o_done, o_pass, o_timeout;
  logic [NC-1:0] o_fail_mask, o_halted_mask;
  logic [31:0]   o_cycles;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  int          p_h0, p_h1, p_rep0, p_abort, p_start;
  logic [31:0] p_c0, p_c1, p_rc0;

  riscv_run_controller #(
    .NUM_CORES(NC), .RESET_CYCLES(RC), .MAX_CYCLES(MC), .CNT_W(32)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_halt        (i_halt),
    .i_halt_code   (i_halt_code),
    .o_core_rstn   (o_core_rstn),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_pass        (o_pass),
    .o_timeout     (o_timeout),
    .o_fail_mask   (o_fail_mask),
    .o_halted_mask (o_halted_mask),
    .o_cycles      (o_cycles)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_result(input logic pass, input logic tmo, input logic [1:0] fail,
                               input logic [1:0] halted, input int cycles);
    exp_t e;
    e.pass = pass; e.timeout = tmo; e.fail = fail; e.halted = halted; e.cycles = cycles;
    exp_q.push_back(e);
  endtask

  task automatic set_plan(input int h0, input logic [31:0] c0, input int h1, input logic [31:0] c1,
                          input int rep0, input logic [31:0] rc0, input int abrt, input int strt);
    p_h0 = h0; p_c0 = c0; p_h1 = h1; p_c1 = c1;
    p_rep0 = rep0; p_rc0 = rc0; p_abort = abrt; p_start = strt;
  endtask

  // Pulse start, then drive halts/abort/start at the planned RUN cycles until idle.
  task automatic do_run(input string tag);
    int guard = 0;
    int rst_low = 0;
    int cyc;
    bit first = 1'b1;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    while (o_busy && guard < 2000) begin
      i_halt = '0; i_abort = 1'b0; i_start = 1'b0;
      if (first) begin
        check({tag, "_clr_halted"}, o_halted_mask, 0);
        check({tag, "_clr_cycles"}, o_cycles, 0);
        first = 1'b0;
      end
      if (o_core_rstn == '0) begin
        rst_low++;
      end else begin
        cyc = int'(o_cycles);
        if (cyc == p_h0)    begin i_halt[0] = 1'b1; i_halt_code[31:0]  = p_c0;  end
        if (cyc == p_rep0)  begin i_halt[0] = 1'b1; i_halt_code[31:0]  = p_rc0; end
        if (cyc == p_h1)    begin i_halt[1] = 1'b1; i_halt_code[63:32] = p_c1;  end
        if (cyc == p_abort) i_abort = 1'b1;
        if (cyc == p_start) i_start = 1'b1;
      end
      @(negedge i_clk);
      guard++;
    end
    i_halt = '0; i_abort = 1'b0; i_start = 1'b0;
    check({tag, "_run_ended"}, o_busy, 0);
    check({tag, "_reset_hold"}, rst_low, RC);
  endtask

  // Monitor: on each rising o_done compare against the oldest expected verdict.
  logic prev_done = 1'b0;
  always @(negedge i_clk) begin
    exp_t e;
    if (o_done && !prev_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("mon_pass",    o_pass,        e.pass);
        check("mon_timeout", o_timeout,     e.timeout);
        check("mon_fail",    o_fail_mask,   e.fail);
        check("mon_halted",  o_halted_mask, e.halted);
        check("mon_cycles",  o_cycles,      e.cycles);
        check("mon_rstn",    o_core_rstn,   0);
      end
    end
    prev_done <= o_done;
  end

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_halt = '0; i_halt_code = '0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    check("rst_busy",   o_busy, 0);
    check("rst_done",   o_done, 0);
    check("rst_rstn",   o_core_rstn, 0);
    check("rst_cycles", o_cycles, 0);
    check("rst_halted", o_halted_mask, 0);
    check("rst_fail",   o_fail_mask, 0);

    // Both cores halt with code 0 at cycle 50.
    set_plan(50, 0, 50, 0, -1, 0, -1, -1);
    expect_result(1, 0, 2'b00, 2'b11, 51);
    do_run("pass50");

    // Restart from PASS: core1 exits with code 3.
    set_plan(10, 0, 20, 3, -1, 0, -1, -1);
    expect_result(0, 0, 2'b10, 2'b11, 21);
    do_run("fail");

    // Synchronous reset from a done state clears held results.
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("rstdone_done",   o_done, 0);
    check("rstdone_halted", o_halted_mask, 0);
    check("rstdone_fail",   o_fail_mask, 0);
    check("rstdone_cycles", o_cycles, 0);

    // No halt: timeout, results held afterwards.
    set_plan(-1, 0, -1, 0, -1, 0, -1, -1);
    expect_result(0, 1, 2'b00, 2'b00, MC);
    do_run("tmo");
    repeat (5) @(negedge i_clk);
    check("tmo_hold_flag",   o_timeout, 1);
    check("tmo_hold_cycles", o_cycles, MC);

    // Completing halt on the last budget cycle wins over timeout.
    set_plan(5, 0, MC - 1, 0, -1, 0, -1, -1);
    expect_result(1, 0, 2'b00, 2'b11, MC);
    do_run("edge");

    // Repeat halt with code 5 is ignored; start during RUN is ignored.
    set_plan(10, 0, 40, 0, 15, 5, -1, 20);
    expect_result(1, 0, 2'b00, 2'b11, 41);
    do_run("repeat");

    // Abort at cycle 30 after core0 halted with code 7.
    set_plan(10, 7, -1, 0, -1, 0, 30, -1);
    do_run("abort");
    check("abort_done",   o_done, 0);
    check("abort_rstn",   o_core_rstn, 0);
    check("abort_cycles", o_cycles, 30);
    check("abort_halted", o_halted_mask, 2'b01);
    check("abort_fail",   o_fail_mask, 2'b01);

    // Reset asserted in the middle of RESET.
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    check("midrst_busy_before", o_busy, 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("midrst_busy",   o_busy, 0);
    check("midrst_done",   o_done, 0);
    check("midrst_rstn",   o_core_rstn, 0);
    check("midrst_cycles", o_cycles, 0);
    check("midrst_halted", o_halted_mask, 0);
    repeat (3) @(negedge i_clk);
    check("midrst_stays_idle", o_busy, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_run_controller.md
# riscv_run_controller

Synthesizable run controller for the pipelined RV32I core and its multi-core successors. It sequences core reset, counts execution cycles, and detects per-core halt with exit codes. It flags pass, fail or timeout, replacing fixed-duration reset-and-wait stimulus with a reusable on-chip block. It sits between the SoC reset/test infrastructure and one or more cores' active-low reset inputs.

## Interface
- NUM_CORES, 1: number of monitored cores (1..8)
- RESET_CYCLES, 4: cycles core reset is held low after start (≥1)
- MAX_CYCLES, 200: RUN-cycle budget before timeout (≥2)
- CNT_W, 32: cycle counter width; MAX_CYCLES must fit
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse: begin a run (accepted in IDLE or any DONE state)
- i_abort  in  1  cancel active run (RESET or RUN)
- i_halt  in  NUM_CORES  per-core halt strobe (e.g. ecall/ebreak retire)
- i_halt_code  in  32*NUM_CORES  exit code of core k on bits [32k+31:32k], valid with i_halt[k]
- o_core_rstn  out  NUM_CORES  active-low reset to each core
- o_busy  out  1  high in RESET or RUN
- o_done  out  1  high in PASS, FAIL or TIMEOUT
- o_pass  out  1  high in PASS only
- o_timeout  out  1  high in TIMEOUT only
- o_fail_mask  out  NUM_CORES  cores halted with nonzero code
- o_halted_mask  out  NUM_CORES  sticky per-core halted flags
- o_cycles  out  CNT_W  RUN cycles elapsed in current/last run

## Operation
- States: IDLE, RESET, RUN, PASS, FAIL, TIMEOUT.
- IDLE: cores held in reset; i_start → RESET, clears counters, masks and codes.
- RESET: o_core_rstn all 0; reset counter counts RESET_CYCLES cycles, then → RUN.
- RUN: o_core_rstn all 1; o_cycles increments every RUN cycle.
- Halt capture, per core: first i_halt[k] in RUN sets o_halted_mask[k] and latches the code. Later strobes from that core are ignored (first code wins). Halts outside RUN are ignored.
- Completion: when (o_halted_mask | i_halt) is all ones, go next edge to PASS if every captured code (including same-cycle ones) is zero, else FAIL.
- Timeout: if o_cycles == MAX_CYCLES-1 and completion is not met this cycle → TIMEOUT.
- Simultaneous completion and timeout in the same cycle: completion wins.
- i_abort in RESET/RUN → IDLE next edge; masks and o_cycles retain their values. i_abort has priority over completion and timeout.
- PASS/FAIL/TIMEOUT: cores return to reset (o_core_rstn = 0); all results are held stable until i_start, which behaves as from IDLE.
- i_start while busy is ignored.
- o_fail_mask[k] = halted[k] & (code[k] != 0); it updates as halts are captured.

## Timing
- i_rst sampled high at an edge: state IDLE, o_core_rstn all 0, all masks/counters/codes 0, all status outputs 0. This applies mid-run too.
- All outputs are registered or derived from state only; no combinational path from inputs to outputs.
- i_start at edge t → RESET from t+1; o_core_rstn rises at edge t+1+RESET_CYCLES.
- First RUN cycle: o_cycles = 0; after N RUN cycles o_cycles = N. On timeout, o_cycles = MAX_CYCLES.
- Halt at RUN cycle n (o_cycles = n) completing the set → o_done high after the next edge, with o_cycles = n+1.
- Counter never wraps; the timeout guarantees o_cycles ≤ MAX_CYCLES.

## Structure
- Package riscv_run_pkg: state enum, state encoding, EXIT_PASS = 32'h0 constant.
- Sub-module riscv_halt_capture: per-core sticky halt flag and code register with enable and clear. Instantiated NUM_CORES times via generate.
- The top level holds the FSM, reset counter and cycle counter.

## Test plan
- NUM_CORES=1, start, core strobes halt code 0 at RUN cycle 50 → o_pass=1, o_cycles=51, o_core_rstn low for exactly 4 cycles at start.
- NUM_CORES=2, core0 halts code 0 at cycle 10, core1 halts code 3 at cycle 20 → FAIL, o_fail_mask=2'b10, o_halted_mask=2'b11.
- No halt → TIMEOUT with o_cycles=200; final halt landing at o_cycles=199 → PASS, not TIMEOUT.
- Repeat halt on core0 with new code 5 after code 0 → still counted as code 0; i_start during RUN → no effect.
- i_abort at RUN cycle 30 → IDLE, cores in reset, o_cycles=30 held; i_rst mid-RESET → all outputs zero next edge.
- Restart from PASS via i_start → masks cleared, second run completes independently.
